// File: rtl/image_op_sequencer.sv
// image_op_sequencer: queues frame commands, validates them, then scans the
// source frame in raster order and produces a delayed write strobe that
// accompanies each read through a MEM_LATENCY-deep pipeline.
// Optional feature: define IMAGE_OP_SEQ_FRAME_CNT_EN to add a 16-bit
// FRAME_COUNT output counting completed frames.
module image_op_sequencer #(
  parameter int MAX_WIDTH   = 1080,
  parameter int MAX_HEIGHT  = 1080,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OPCODE,
  input  logic [11:0] CMD_WIDTH,
  input  logic [11:0] CMD_HEIGHT,
  input  logic        STALL,
  output logic [1:0]  PROC_OPCODE,
  output logic [11:0] PROC_WIDTH,
  output logic [11:0] PROC_HEIGHT,
  output logic [11:0] READ_ROW,
  output logic [11:0] READ_COL,
  output logic        RD_EN,
  output logic        WR_EN,
  output logic [11:0] WR_ROW,
  output logic [11:0] WR_COL,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        CMD_ERR
`ifdef IMAGE_OP_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0] FRAME_COUNT
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [12:0] MAX_W13 = 13'(MAX_WIDTH);
  localparam logic [12:0] MAX_H13 = 13'(MAX_HEIGHT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Command queue: {opcode, width, height}
  logic [25:0]      fifo_mem_q [FIFO_DEPTH];
  logic [25:0]      fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]  proc_opcode_q, proc_opcode_d;
  logic [11:0] proc_width_q, proc_width_d;
  logic [11:0] proc_height_q, proc_height_d;
  logic [11:0] read_row_q, read_row_d;
  logic [11:0] read_col_q, read_col_d;

  logic        pipe_valid_q [MEM_LATENCY];
  logic        pipe_valid_d [MEM_LATENCY];
  logic [11:0] pipe_row_q [MEM_LATENCY];
  logic [11:0] pipe_row_d [MEM_LATENCY];
  logic [11:0] pipe_col_q [MEM_LATENCY];
  logic [11:0] pipe_col_d [MEM_LATENCY];

`ifdef IMAGE_OP_SEQ_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;
`endif

  logic        fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [1:0]  head_op_s;
  logic [11:0] head_w_s, head_h_s;
  logic        head_ok_s;
  logic        rd_en_s, frame_done_s, cmd_err_s, scan_stall_s;
  logic        last_addr_s, last_col_s, pipe_pending_s;

  assign fifo_full_s  = (count_q == FULL_CNT);
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign head_op_s    = fifo_mem_q[rd_ptr_q][25:24];
  assign head_w_s     = fifo_mem_q[rd_ptr_q][23:12];
  assign head_h_s     = fifo_mem_q[rd_ptr_q][11:0];
  assign head_ok_s    = (head_op_s != 2'd3) &&
                        (head_w_s != 12'd0) && ({1'b0, head_w_s} <= MAX_W13) &&
                        (head_h_s != 12'd0) && ({1'b0, head_h_s} <= MAX_H13);
  // Column/row limits always use the latched frame size, not the queue head
  assign last_col_s   = (read_col_q == (proc_width_q - 12'd1));
  assign last_addr_s  = last_col_s && (read_row_q == (proc_height_q - 12'd1));

  // Ready is held low while reset is asserted so nothing is accepted then
  assign CMD_READY = RESET && !fifo_full_s;
  assign push_s    = CMD_VALID && CMD_READY;

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = fifo_empty_s ? S_IDLE : S_LOAD;
      S_LOAD:  state_d = head_ok_s ? S_SCAN : S_IDLE;
      S_SCAN:  state_d = (rd_en_s && last_addr_s) ? S_DRAIN : S_SCAN;
      S_DRAIN: state_d = pipe_pending_s ? S_DRAIN : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded strobes; STALL only matters while scanning or draining
  always_comb begin
    rd_en_s      = 1'b0;
    pop_s        = 1'b0;
    cmd_err_s    = 1'b0;
    frame_done_s = 1'b0;
    scan_stall_s = 1'b0;
    case (state_q)
      S_IDLE: begin
      end
      S_LOAD: begin
        pop_s     = 1'b1;
        cmd_err_s = !head_ok_s;
      end
      S_SCAN: begin
        rd_en_s      = !STALL;
        scan_stall_s = STALL;
      end
      S_DRAIN: begin
        scan_stall_s = STALL;
      end
      S_DONE: begin
        frame_done_s = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Queue bookkeeping: simultaneous push and pop keep the occupancy
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = {CMD_OPCODE, CMD_WIDTH, CMD_HEIGHT};
      wr_ptr_d             = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Frame parameters and raster address generation
  always_comb begin
    proc_opcode_d = proc_opcode_q;
    proc_width_d  = proc_width_q;
    proc_height_d = proc_height_q;
    read_row_d    = read_row_q;
    read_col_d    = read_col_q;
    if ((state_q == S_LOAD) && head_ok_s) begin
      proc_opcode_d = head_op_s;
      proc_width_d  = head_w_s;
      proc_height_d = head_h_s;
      read_row_d    = 12'd0;
      read_col_d    = 12'd0;
    end else if (rd_en_s && !last_addr_s) begin
      if (last_col_s) begin
        read_col_d = 12'd0;
        read_row_d = read_row_q + 12'd1;
      end else begin
        read_col_d = read_col_q + 12'd1;
      end
    end else begin
      read_row_d = read_row_q;
    end
  end

  // Read-to-write delay line, frozen while stalled
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_row_d   = pipe_row_q;
    pipe_col_d   = pipe_col_q;
    if (!scan_stall_s) begin
      pipe_valid_d[0] = rd_en_s;
      pipe_row_d[0]   = read_row_q;
      pipe_col_d[0]   = read_col_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid_d[i] = pipe_valid_q[i-1];
        pipe_row_d[i]   = pipe_row_q[i-1];
        pipe_col_d[i]   = pipe_col_q[i-1];
      end
    end else begin
      pipe_valid_d[0] = pipe_valid_q[0];
    end
    // Drain ends once nothing remains after this cycle's write
    pipe_pending_s = 1'b0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      pipe_pending_s = pipe_pending_s | pipe_valid_d[i];
    end
  end

`ifdef IMAGE_OP_SEQ_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 16 bits
  always_comb begin
    if (frame_done_s) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end
`endif

  // Queue storage (contents need no reset; occupancy guards them)
  always_ff @(posedge CLK) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // Control and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      proc_opcode_q <= 2'd0;
      proc_width_q  <= 12'd0;
      proc_height_q <= 12'd0;
      read_row_q    <= 12'd0;
      read_col_q    <= 12'd0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_row_q[i]   <= 12'd0;
        pipe_col_q[i]   <= 12'd0;
      end
`ifdef IMAGE_OP_SEQ_FRAME_CNT_EN
      frame_count_q <= 16'd0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      proc_opcode_q <= proc_opcode_d;
      proc_width_q  <= proc_width_d;
      proc_height_q <= proc_height_d;
      read_row_q    <= read_row_d;
      read_col_q    <= read_col_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_row_q    <= pipe_row_d;
      pipe_col_q    <= pipe_col_d;
`ifdef IMAGE_OP_SEQ_FRAME_CNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign PROC_OPCODE = proc_opcode_q;
  assign PROC_WIDTH  = proc_width_q;
  assign PROC_HEIGHT = proc_height_q;
  assign READ_ROW    = read_row_q;
  assign READ_COL    = read_col_q;
  assign RD_EN       = rd_en_s;
  assign WR_EN       = pipe_valid_q[MEM_LATENCY-1] && !scan_stall_s;
  assign WR_ROW      = pipe_row_q[MEM_LATENCY-1];
  assign WR_COL      = pipe_col_q[MEM_LATENCY-1];
  assign BUSY        = (state_q != S_IDLE);
  assign FRAME_DONE  = frame_done_s;
  assign CMD_ERR     = cmd_err_s;
`ifdef IMAGE_OP_SEQ_FRAME_CNT_EN
  assign FRAME_COUNT = frame_count_q;
`endif

endmodule
